// File: rtl/cond_issue_ctrl.sv
// Conditional-issue controller: owns NZCV, tracks in-flight flag writers and holds a
// conditional instruction until its flags are final, then issues it with a pass/kill verdict.
module cond_issue_ctrl #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [3:0]        dec_cond,
  input  logic [1:0]        dec_flag_w,
  output logic              dec_ready,
  input  logic              wb_valid,
  input  logic [1:0]        wb_flag_w,
  input  logic [3:0]        wb_flags,
  output logic              ex_valid,
  output logic              ex_cond_ex,
  output logic [1:0]        ex_flag_w,
  output logic [3:0]        flags_q,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              err
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [0:0]        state_q, state_d;
  logic [3:0]        hold_cond_q, hold_cond_d;
  logic [1:0]        hold_flag_w_q, hold_flag_w_d;
  logic              ex_valid_q, ex_valid_d;
  logic              ex_cond_ex_q, ex_cond_ex_d;
  logic [1:0]        ex_flag_w_q, ex_flag_w_d;
  logic              err_q, err_d;
  logic [3:0]        flags_d;
  logic [PEND_W-1:0] pend_nx, pend_d;
  logic              accept;
  logic              issue;
  logic [3:0]        issue_cond;
  logic [1:0]        issue_flag_w;

  // {N,Z,C,V} = f[3:0]
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = c;
      4'b0011: cond_eval = !c;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = c && !z;
      4'b1001: cond_eval = !c || z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = !z && (n == v);
      4'b1101: cond_eval = z || (n != v);
      default: cond_eval = 1'b1;
    endcase
  endfunction

  assign dec_ready = (state_q == ST_RUN) && (pend_cnt != PEND_MAX);
  assign accept    = dec_valid && dec_ready;

  always_comb begin
    flags_d = flags_q;
    if (wb_valid && wb_flag_w[1]) flags_d[3:2] = wb_flags[3:2];
    if (wb_valid && wb_flag_w[0]) flags_d[1:0] = wb_flags[1:0];
  end

  // A writeback with nothing outstanding is flagged, not allowed to wrap the counter.
  always_comb begin
    err_d   = err_q;
    pend_nx = pend_cnt;
    if (wb_valid) begin
      if (pend_cnt == '0) err_d = 1'b1;
      else                pend_nx = pend_cnt - PEND_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_cond_d   = hold_cond_q;
    hold_flag_w_d = hold_flag_w_q;
    issue         = 1'b0;
    issue_cond    = dec_cond;
    issue_flag_w  = dec_flag_w;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (dec_cond[3:1] == 3'b111 || pend_nx == '0) begin
            issue = 1'b1;
          end else begin
            hold_cond_d   = dec_cond;
            hold_flag_w_d = dec_flag_w;
            state_d       = ST_WAIT;
          end
        end
      end
      default: begin
        issue_cond   = hold_cond_q;
        issue_flag_w = hold_flag_w_q;
        if (pend_nx == '0) begin
          issue   = 1'b1;
          state_d = ST_RUN;
        end
      end
    endcase
    ex_valid_d   = issue;
    ex_cond_ex_d = issue && cond_eval(issue_cond, flags_d);
    ex_flag_w_d  = issue_flag_w & {2{ex_cond_ex_d}};
    pend_d       = pend_nx + PEND_W'(issue && (ex_flag_w_d != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      hold_cond_q   <= '0;
      hold_flag_w_q <= '0;
      ex_valid_q    <= 1'b0;
      ex_cond_ex_q  <= 1'b0;
      ex_flag_w_q   <= '0;
      flags_q       <= '0;
      pend_cnt      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cond_q   <= hold_cond_d;
      hold_flag_w_q <= hold_flag_w_d;
      ex_valid_q    <= ex_valid_d;
      ex_cond_ex_q  <= ex_cond_ex_d;
      ex_flag_w_q   <= ex_flag_w_d;
      flags_q       <= flags_d;
      pend_cnt      <= pend_d;
      err_q         <= err_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_cond_ex = ex_cond_ex_q;
  assign ex_flag_w  = ex_flag_w_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed bench for cond_issue_ctrl: linear stimulus with hand-computed expectations.
module tb_cond_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic [3:0] dec_cond;
  logic [1:0] dec_flag_w;
  logic       dec_ready;
  logic       wb_valid;
  logic [1:0] wb_flag_w;
  logic [3:0] wb_flags;
  logic       ex_valid;
  logic       ex_cond_ex;
  logic [1:0] ex_flag_w;
  logic [3:0] flags_q;
  logic [1:0] pend_cnt;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_issue_ctrl #(.PEND_W(2)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_cond(dec_cond), .dec_flag_w(dec_flag_w), .dec_ready(dec_ready),
    .wb_valid(wb_valid), .wb_flag_w(wb_flag_w), .wb_flags(wb_flags),
    .ex_valid(ex_valid), .ex_cond_ex(ex_cond_ex), .ex_flag_w(ex_flag_w),
    .flags_q(flags_q), .pend_cnt(pend_cnt), .err(err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic v, input logic [3:0] c, input logic [1:0] fw);
    dec_valid  = v;
    dec_cond   = c;
    dec_flag_w = fw;
  endtask

  task automatic wb(input logic v, input logic [1:0] fw, input logic [3:0] f);
    wb_valid  = v;
    wb_flag_w = fw;
    wb_flags  = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic v, input logic ce, input logic [1:0] fw);
    chk({tag, ".ex_valid"}, {7'd0, ex_valid}, {7'd0, v});
    chk({tag, ".ex_cond_ex"}, {7'd0, ex_cond_ex}, {7'd0, ce});
    chk({tag, ".ex_flag_w"}, {6'd0, ex_flag_w}, {6'd0, fw});
  endtask

  initial begin
    reset = 1'b1;
    dec(1'b0, 4'h0, 2'b00);
    wb(1'b0, 2'b00, 4'h0);
    tick();
    tick();
    chk_ex("reset", 1'b0, 1'b0, 2'b00);
    chk("reset.flags", {4'd0, flags_q}, 8'h00);
    chk("reset.pend", {6'd0, pend_cnt}, 8'h00);
    chk("reset.err", {7'd0, err}, 8'h00);
    chk("reset.ready", {7'd0, dec_ready}, 8'h01);
    $display("txn reset done");
    @(negedge clk);
    reset = 1'b0;

    // EQ with Z=0 is killed and its flag write is gated off
    dec(1'b1, 4'b0000, 2'b11);
    tick();
    chk_ex("eq_kill", 1'b1, 1'b0, 2'b00);
    chk("eq_kill.pend", {6'd0, pend_cnt}, 8'h00);
    $display("txn EQ kill");

    dec(1'b1, 4'b1110, 2'b11);
    tick();
    chk_ex("al_w11", 1'b1, 1'b1, 2'b11);
    chk("al_w11.pend", {6'd0, pend_cnt}, 8'h01);
    $display("txn AL w11");

    // NE with a writer outstanding must wait
    dec(1'b1, 4'b0001, 2'b00);
    tick();
    chk("ne_wait.ex_valid", {7'd0, ex_valid}, 8'h00);
    chk("ne_wait.ready", {7'd0, dec_ready}, 8'h00);
    chk("ne_wait.pend", {6'd0, pend_cnt}, 8'h01);
    $display("txn NE stalled");

    dec(1'b0, 4'h0, 2'b00);
    wb(1'b1, 2'b11, 4'b0100);
    tick();
    chk_ex("ne_issue", 1'b1, 1'b0, 2'b00);
    chk("ne_issue.pend", {6'd0, pend_cnt}, 8'h00);
    chk("ne_issue.flags", {4'd0, flags_q}, 8'h04);
    chk("ne_issue.ready", {7'd0, dec_ready}, 8'h01);
    $display("txn NE issued on writeback");

    wb(1'b0, 2'b00, 4'h0);
    dec(1'b1, 4'b0000, 2'b00);
    tick();
    chk_ex("eq_pass", 1'b1, 1'b1, 2'b00);
    $display("txn EQ pass");

    dec(1'b1, 4'b1110, 2'b11);
    tick();
    chk("al2.pend", {6'd0, pend_cnt}, 8'h01);
    // GE accepted in the same cycle as its producer's writeback: bypass, no stall
    dec(1'b1, 4'b1010, 2'b10);
    wb(1'b1, 2'b11, 4'b1001);
    tick();
    chk_ex("ge_bypass", 1'b1, 1'b1, 2'b10);
    chk("ge_bypass.pend", {6'd0, pend_cnt}, 8'h01);
    chk("ge_bypass.flags", {4'd0, flags_q}, 8'h09);
    $display("txn GE bypass");

    dec(1'b0, 4'h0, 2'b00);
    wb(1'b1, 2'b10, 4'b0000);
    tick();
    chk("drain1.ex_valid", {7'd0, ex_valid}, 8'h00);
    chk("drain1.pend", {6'd0, pend_cnt}, 8'h00);
    chk("drain1.flags", {4'd0, flags_q}, 8'h01);
    $display("txn drain NZ");

    wb(1'b0, 2'b00, 4'h0);
    for (int i = 0; i < 3; i++) begin
      dec(1'b1, 4'b1110, 2'b01);
      tick();
      chk("al_fill.pend", {6'd0, pend_cnt}, 8'(i + 1));
      $display("txn AL fill %0d", i);
    end
    chk("full.ready", {7'd0, dec_ready}, 8'h00);
    tick();
    chk("full.ex_valid", {7'd0, ex_valid}, 8'h00);
    chk("full.pend", {6'd0, pend_cnt}, 8'h03);
    dec(1'b0, 4'h0, 2'b00);
    wb(1'b1, 2'b01, 4'b0010);
    tick();
    chk("unfull.pend", {6'd0, pend_cnt}, 8'h02);
    chk("unfull.ready", {7'd0, dec_ready}, 8'h01);
    chk("unfull.flags", {4'd0, flags_q}, 8'h02);
    $display("txn counter full then release");

    wb(1'b1, 2'b00, 4'b1111);
    tick();
    tick();
    chk("drain2.pend", {6'd0, pend_cnt}, 8'h00);
    chk("drain2.flags", {4'd0, flags_q}, 8'h02);
    wb(1'b0, 2'b00, 4'h0);
    dec(1'b1, 4'b1000, 2'b00);
    tick();
    chk_ex("hi_pass", 1'b1, 1'b1, 2'b00);
    $display("txn HI pass");

    // Orphan writeback: err sticks, counter stays at 0, flags still update
    dec(1'b0, 4'h0, 2'b00);
    wb(1'b1, 2'b10, 4'b1100);
    tick();
    chk("orphan.err", {7'd0, err}, 8'h01);
    chk("orphan.pend", {6'd0, pend_cnt}, 8'h00);
    chk("orphan.flags", {4'd0, flags_q}, 8'h0E);
    wb(1'b0, 2'b00, 4'h0);
    dec(1'b1, 4'b1011, 2'b00);
    tick();
    chk("orphan.err_sticky", {7'd0, err}, 8'h01);
    chk_ex("lt_pass", 1'b1, 1'b1, 2'b00);
    dec(1'b1, 4'b1100, 2'b11);
    tick();
    chk_ex("gt_kill", 1'b1, 1'b0, 2'b00);
    $display("txn orphan writeback, LT, GT");

    dec(1'b1, 4'b1110, 2'b11);
    tick();
    dec(1'b1, 4'b0100, 2'b11);
    tick();
    chk("mi_wait.ready", {7'd0, dec_ready}, 8'h00);
    dec(1'b0, 4'h0, 2'b00);
    reset = 1'b1;
    tick();
    chk_ex("rst_wait", 1'b0, 1'b0, 2'b00);
    chk("rst_wait.pend", {6'd0, pend_cnt}, 8'h00);
    chk("rst_wait.err", {7'd0, err}, 8'h00);
    chk("rst_wait.flags", {4'd0, flags_q}, 8'h00);
    chk("rst_wait.ready", {7'd0, dec_ready}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst.ex_valid", {7'd0, ex_valid}, 8'h00);
    end
    $display("txn reset in WAIT");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
